// File: rtl/card_testreg_pkg.sv
// Shared definitions for the card test-register block: register offsets,
// AXI response codes, register index type and byte-strobe merge helper.
package card_testreg_pkg;

  localparam logic [3:0] REG1_OFF = 4'h0;
  localparam logic [3:0] REG2_OFF = 4'h4;
  localparam logic [3:0] REG3_OFF = 4'h8;
  localparam logic [3:0] REG4_OFF = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDX_REG1 = 2'd0,
    IDX_REG2 = 2'd1,
    IDX_REG3 = 2'd2,
    IDX_REG4 = 2'd3
  } reg_idx_e;

  // Low address nibble to register index; byte lane bits are ignored.
  function automatic reg_idx_e addr_to_idx(input logic [3:0] low);
    reg_idx_e idx;
    case ({low[3:2], 2'b00})
      REG1_OFF: idx = IDX_REG1;
      REG2_OFF: idx = IDX_REG2;
      REG3_OFF: idx = IDX_REG3;
      REG4_OFF: idx = IDX_REG4;
      default:  idx = IDX_REG1;
    endcase
    return idx;
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/card_testreg_axil_if.sv
// AXI4-Lite slave front end: accepts one write and one read at a time,
// decodes the address and holds the registered B and R responses.
module card_testreg_axil_if
  import card_testreg_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic              i_arvalid,
  output logic              o_arready,
  output logic [31:0]       o_rdata,
  output logic [1:0]        o_rresp,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic              o_wr_en,
  output reg_idx_e          o_wr_idx,
  output logic [31:0]       o_wr_data,
  output logic [3:0]        o_wr_strb,
  output logic              o_wr_err,
  output logic              o_rd_en,
  output reg_idx_e          o_rd_idx,
  output logic              o_rd_err,
  input  logic [31:0]       i_rd_data
);

  logic        w_wr_acc;
  logic        w_rd_acc;
  logic        w_wr_err;
  logic        w_rd_err;
  logic        w_unused_addr;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  // Ready is combinational so a transfer completes every second cycle;
  // it is masked during reset so no handshake can be seen then.
  assign w_wr_acc = i_awvalid & i_wvalid & ~r_bvalid & ~i_rst;
  assign w_rd_acc = i_arvalid & ~r_rvalid & ~i_rst;

  assign w_wr_err      = (i_awaddr[ADDR_W-1:4] != '0);
  assign w_rd_err      = (i_araddr[ADDR_W-1:4] != '0);
  assign w_unused_addr = ^{i_awaddr[1:0], i_araddr[1:0]};

  assign o_awready = w_wr_acc;
  assign o_wready  = w_wr_acc;
  assign o_arready = w_rd_acc;

  assign o_wr_en   = w_wr_acc;
  assign o_wr_idx  = addr_to_idx(i_awaddr[3:0]);
  assign o_wr_data = i_wdata;
  assign o_wr_strb = i_wstrb;
  assign o_wr_err  = w_wr_err;
  assign o_rd_en   = w_rd_acc;
  assign o_rd_idx  = addr_to_idx(i_araddr[3:0]);
  assign o_rd_err  = w_rd_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_acc) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_bvalid && i_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read data is captured at the handshake, so it is the pre-write value
  // when a write to the same register completes in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= 32'd0;
    end else if (w_rd_acc) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      r_rdata  <= i_rd_data;
    end else if (r_rvalid && i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign o_bvalid = r_bvalid;
  assign o_bresp  = r_bresp;
  assign o_rvalid = r_rvalid;
  assign o_rresp  = r_rresp;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/card_testreg.sv
// Card test-register block: REG1/REG2 operands, registered sum in REG3,
// REG4 scratch, all behind an AXI4-Lite slave.
module card_testreg
  import card_testreg_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [DATA_W-1:0] s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [DATA_W-1:0] s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready
);

  logic        w_wr_en;
  reg_idx_e    w_wr_idx;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_wr_err;
  logic        w_rd_en;
  reg_idx_e    w_rd_idx;
  logic        w_rd_err;
  logic [31:0] w_rd_data;
  logic [31:0] r_reg1;
  logic [31:0] r_reg2;
  logic [31:0] r_reg3;
  logic [31:0] r_reg4;

  card_testreg_axil_if #(
    .ADDR_W (ADDR_W)
  ) u_axil_if (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_awaddr  (s_axil_awaddr),
    .i_awvalid (s_axil_awvalid),
    .o_awready (s_axil_awready),
    .i_wdata   (s_axil_wdata),
    .i_wstrb   (s_axil_wstrb),
    .i_wvalid  (s_axil_wvalid),
    .o_wready  (s_axil_wready),
    .o_bresp   (s_axil_bresp),
    .o_bvalid  (s_axil_bvalid),
    .i_bready  (s_axil_bready),
    .i_araddr  (s_axil_araddr),
    .i_arvalid (s_axil_arvalid),
    .o_arready (s_axil_arready),
    .o_rdata   (s_axil_rdata),
    .o_rresp   (s_axil_rresp),
    .o_rvalid  (s_axil_rvalid),
    .i_rready  (s_axil_rready),
    .o_wr_en   (w_wr_en),
    .o_wr_idx  (w_wr_idx),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .o_wr_err  (w_wr_err),
    .o_rd_en   (w_rd_en),
    .o_rd_idx  (w_rd_idx),
    .o_rd_err  (w_rd_err),
    .i_rd_data (w_rd_data)
  );

  // REG3 trails the operands by one cycle; writes to it are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg1 <= 32'd0;
      r_reg2 <= 32'd0;
      r_reg3 <= 32'd0;
      r_reg4 <= 32'd0;
    end else begin
      r_reg3 <= r_reg1 + r_reg2;
      if (w_wr_en && !w_wr_err) begin
        case (w_wr_idx)
          IDX_REG1: r_reg1 <= apply_wstrb(r_reg1, w_wr_data, w_wr_strb);
          IDX_REG2: r_reg2 <= apply_wstrb(r_reg2, w_wr_data, w_wr_strb);
          IDX_REG4: r_reg4 <= apply_wstrb(r_reg4, w_wr_data, w_wr_strb);
          default:  r_reg4 <= r_reg4;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_data = 32'd0;
    if (w_rd_en && !w_rd_err) begin
      case (w_rd_idx)
        IDX_REG1: w_rd_data = r_reg1;
        IDX_REG2: w_rd_data = r_reg2;
        IDX_REG3: w_rd_data = r_reg3;
        IDX_REG4: w_rd_data = r_reg4;
        default:  w_rd_data = 32'd0;
      endcase
    end else begin
      w_rd_data = 32'd0;
    end
  end

endmodule

// File: tb/tb_card_testreg.sv
// Self-checking bench for card_testreg: directed scenarios plus random
// traffic checked against an array model of the register map.
module tb_card_testreg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [15:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  card_testreg #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready), .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
    .s_axil_bready(bready), .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  // Register-map view: REG3 is the 32-bit wrapping sum, unmapped reads are zero.
  function automatic logic [31:0] model_read(input logic [15:0] addr);
    if (addr[15:4] != 12'd0) return 32'd0;
    if (addr[3:2] == 2'd2) return model[0] + model[1];
    return model[addr[3:2]];
  endfunction

  function automatic logic [1:0] model_resp(input logic [15:0] addr);
    return (addr[15:4] != 12'd0) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    if (addr[15:4] == 12'd0 && addr[3:2] != 2'd2) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit acc = 1'b0;
    bit got = 1'b0;
    resp = 2'bxx;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1 acc = awready && wready;
      @(posedge clk);
    end
    #1 awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20 && acc && !got; i++) begin
      @(negedge clk);
      if (bvalid) begin got = 1'b1; resp = bresp; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL write_timeout addr=%h accepted=%0d bvalid_seen=%0d required=1", addr, acc, got);
    end
  endtask

  task automatic axi_read(input logic [15:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit acc = 1'b0;
    bit got = 1'b0;
    data = 32'hxxxxxxxx; resp = 2'bxx;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1 acc = arready;
      @(posedge clk);
    end
    #1 arvalid = 1'b0;
    for (int i = 0; i < 20 && acc && !got; i++) begin
      @(negedge clk);
      if (rvalid) begin got = 1'b1; data = rdata; resp = rresp; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL read_timeout addr=%h accepted=%0d rvalid_seen=%0d required=1", addr, acc, got);
    end
  endtask

  task automatic write_and_check(input string name, input logic [15:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] resp;
    axi_write(addr, data, strb, resp);
    n_checks++;
    if (resp !== model_resp(addr)) begin
      n_fail++;
      $display("FAIL %s bresp addr=%h got=%b exp=%b", name, addr, resp, model_resp(addr));
    end
    model_write(addr, data, strb);
  endtask

  task automatic read_and_check(input string name, input logic [15:0] addr);
    logic [31:0] d;
    logic [1:0]  resp;
    axi_read(addr, d, resp);
    n_checks++;
    if (d !== model_read(addr) || resp !== model_resp(addr)) begin
      n_fail++;
      $display("FAIL %s read addr=%h got=%h/%b exp=%h/%b", name, addr, d, resp,
               model_read(addr), model_resp(addr));
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got aw=%b w=%b ar=%b b=%b r=%b bresp=%b rresp=%b rdata=%h exp all 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
    end
    for (int i = 0; i < 4; i++) read_and_check("reset_regs", 16'(4 * i));
  endtask

  task automatic test_sum();
    write_and_check("sum_w1", 16'h0000, 32'h12345678, 4'hF);
    write_and_check("sum_w2", 16'h0004, 32'h11111111, 4'hF);
    repeat (2) @(posedge clk);
    read_and_check("sum_reg3", 16'h0008);
    write_and_check("wrap_w1", 16'h0000, 32'hFFFFFFFF, 4'hF);
    write_and_check("wrap_w2", 16'h0004, 32'h00000002, 4'hF);
    read_and_check("wrap_reg3", 16'h0008);
    write_and_check("ro_write", 16'h0008, 32'h0000DEAD, 4'hF);
    read_and_check("ro_reg3", 16'h0008);
  endtask

  task automatic test_strobe();
    write_and_check("strb_clr", 16'h000C, 32'h00000000, 4'hF);
    write_and_check("strb_w", 16'h000C, 32'hAABBCCDD, 4'b0101);
    read_and_check("strb_reg4", 16'h000C);
  endtask

  task automatic test_unmapped();
    write_and_check("unmap_w", 16'h0010, 32'hCAFEF00D, 4'hF);
    read_and_check("unmap_r", 16'h0010);
    for (int i = 0; i < 4; i++) read_and_check("unmap_regs", 16'(4 * i));
  endtask

  task automatic test_handshake();
    @(negedge clk);
    awaddr = 16'h000C; wdata = 32'h5A5A0001; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (awready !== 1'b0 || wready !== 1'b0) begin
        n_fail++;
        $display("FAIL aw_alone cycle=%0d awready=%b wready=%b exp=0/0", i, awready, wready);
      end
      @(negedge clk);
    end
    wvalid = 1'b1;
    #1;
    n_checks++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      n_fail++;
      $display("FAIL aw_w_accept awready=%b wready=%b exp=1/1", awready, wready);
    end
    @(posedge clk); #1;
    wdata = 32'h5A5A0002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        n_fail++;
        $display("FAIL bvalid_hold cycle=%0d bvalid=%b awready=%b wready=%b exp=1/0/0",
                 i, bvalid, awready, wready);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bvalid_drop got=%b exp=0", bvalid);
    end
    model_write(16'h000C, 32'h5A5A0001, 4'hF);
    read_and_check("second_not_taken", 16'h000C);
  endtask

  task automatic test_back_to_back();
    int wcount = 0;
    int rcount = 0;
    @(negedge clk);
    awaddr = 16'h000C; wdata = 32'h0BADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 if (awready) wcount++;
      @(posedge clk);
    end
    #1 awvalid = 1'b0; wvalid = 1'b0;
    model_write(16'h000C, 32'h0BADBEEF, 4'hF);
    n_checks++;
    if (wcount !== 5) begin
      n_fail++;
      $display("FAIL b2b_writes got=%0d exp=5", wcount);
    end
    @(negedge clk);
    araddr = 16'h000C; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 if (arready) rcount++;
      @(posedge clk);
    end
    #1 arvalid = 1'b0;
    n_checks++;
    if (rcount !== 5) begin
      n_fail++;
      $display("FAIL b2b_reads got=%0d exp=5", rcount);
    end
    repeat (2) @(posedge clk);
    read_and_check("b2b_value", 16'h000C);
  endtask

  task automatic test_same_cycle();
    logic [31:0] old_val;
    old_val = model_read(16'h0000);
    @(negedge clk);
    awaddr = 16'h0000; wdata = ~old_val; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 16'h0000; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    #1;
    n_checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_accept awready=%b arready=%b exp=1/1", awready, arready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old_val) begin
      n_fail++;
      $display("FAIL same_cycle_read rvalid=%b bvalid=%b rdata=%h exp=1/1/%h", rvalid, bvalid, rdata, old_val);
    end
    @(posedge clk); #1;
    model_write(16'h0000, ~old_val, 4'hF);
    read_and_check("same_cycle_after", 16'h0000);
  endtask

  task automatic test_random();
    logic [15:0] addr;
    for (int i = 0; i < 60; i++) begin
      addr = {12'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) addr[15:4] = 12'($urandom_range(1, 4095));
      if ($urandom_range(0, 1) == 0)
        write_and_check("rand_w", addr, $urandom, 4'($urandom_range(0, 15)));
      else
        read_and_check("rand_r", addr);
    end
    read_and_check("rand_sum", 16'h0008);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    awaddr = 16'h0000; wdata = 32'h00000055; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    araddr = 16'h0004; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_pending rvalid=%b bvalid=%b exp=1/1", rvalid, bvalid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop rvalid=%b bvalid=%b exp=0/0", rvalid, bvalid);
    end
    @(negedge clk);
    rst = 1'b0; bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_resp_after_reset rvalid=%b bvalid=%b exp=0/0", rvalid, bvalid);
    end
    for (int i = 0; i < 4; i++) read_and_check("post_reset_regs", 16'(4 * i));
  endtask

  initial begin
    rst = 1'b1;
    awaddr = 16'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0;
    bready = 1'b0; araddr = 16'd0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_sum();
    test_strobe();
    test_unmapped();
    test_handshake();
    test_back_to_back();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
